// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Optional macro BIN_TO_BCD_ZERO_SHORTCUT_EN sends a zero operand straight from IDLE to DONE.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned P10 = 64'd10 ** DIGITS;

    if (WIDTH < 4 || WIDTH > 16 || P10 <= MAXV) begin : g_bad_params
        $error("bin_to_bcd_seq: WIDTH must be 4..16 and 10**DIGITS must exceed 2**WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      op_q, op_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d, adj;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        adj     = dig_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = dig_q[4*i +: 4] >= 4'd5 ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
        case (state_q)
            IDLE: if (in_valid) begin
                op_d  = bin;
                dig_d = '0;
                cnt_d = CW'(WIDTH);
`ifdef BIN_TO_BCD_ZERO_SHORTCUT_EN
                state_d = bin == '0 ? DONE : SHIFT;
`else
                state_d = SHIFT;
`endif
            end
            SHIFT: begin
                // Operand MSB moves into digit 0 bit 0; upper digit carry-out is impossible by construction
                {dig_d, op_d} = {adj[4*DIGITS-2:0], op_q, 1'b0};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? DONE : SHIFT;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign bcd       = out_valid ? dig_q : '0;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed bench with a decimal-arithmetic protocol model checked every cycle.
module tb_bin_to_bcd_seq;
    localparam int W = 8;
    localparam int D = 3;
`ifdef BIN_TO_BCD_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W;
`endif

    logic clk = 0;
    logic rst = 1, in_valid = 0, out_ready = 1;
    logic [W-1:0] bin = '0;
    logic in_ready, out_valid;
    logic [4*D-1:0] bcd;
    int checks = 0, errors = 0, cyc = 0;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Protocol model: 0 idle, 1 converting, 2 result offered
    int m_state = 0, m_left = 0, m_val = 0;
    bit m_init = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_init  = 1;
        end else if (m_state == 0) begin
            if (in_valid) begin
                m_val   = int'(bin);
                m_left  = bin == 0 ? ZLAT : W;
                m_state = m_left == 1 && bin == 0 && ZLAT == 1 ? 2 : 1;
            end
        end else if (m_state == 1) begin
            m_left--;
            if (m_left == 0) m_state = 2;
        end else if (out_ready) m_state = 0;
    end

    always @(negedge clk) if (m_init) begin
        chk("in_ready", in_ready, m_state == 0);
        chk("out_valid", out_valid, m_state == 2);
        chk("bcd", bcd, m_state == 2 ? to_bcd(m_val) : '0);
    end

    task automatic convert(input logic [W-1:0] v, output logic [4*D-1:0] res, output int lat);
        int n = 0;
        in_valid = 1;
        bin = v;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0;
        bin = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        res = bcd;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4*D-1:0] r, r1, r2;
        int lat, t1, t2, n, val;
        bit ok;
        chk("model_255", to_bcd(255), 12'h255);
        chk("model_173", to_bcd(173), 12'h173);
        chk("model_42", to_bcd(42), 12'h042);
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bcd", bcd, 0);

        convert(8'd255, r, lat);
        chk("v255_bcd", r, 12'h255);
        chk("v255_lat", lat, 8);
        chk("v255_idle_next", in_ready, 1);

        in_valid = 1;
        bin = 8'd99;
        @(negedge clk);
        t1 = cyc - 1;
        bin = 8'd100;
        n = 0;
        r1 = 'x;
        while (!in_ready && n < 50) begin
            if (out_valid) r1 = bcd;
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        chk("b2b_gap", t2 - t1, 10);
        chk("b2b_99", r1, 12'h099);
        @(negedge clk);
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        r2 = bcd;
        chk("b2b_100", r2, 12'h100);
        @(negedge clk);

        convert(8'd0, r, lat);
        chk("zero_bcd", r, 12'h000);
        chk("zero_lat", lat, ZLAT);

        out_ready = 0;
        in_valid = 1;
        bin = 8'd173;
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("hold_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_bcd", bcd, 12'h173);
            chk("hold_in_ready", in_ready, 0);
            in_valid = 1;
            bin = W'($urandom);
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 1;
        chk("hold_bcd_last", bcd, 12'h173);
        @(negedge clk);
        chk("hold_released", in_ready, 1);
        chk("hold_valid_drop", out_valid, 0);

        in_valid = 1;
        bin = 8'd200;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        in_valid = 1;
        bin = 8'd77;
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_bcd", bcd, 0);
        @(negedge clk);
        chk("abort_not_accepted", in_ready, 1);
        convert(8'd42, r, lat);
        chk("v42_bcd", r, 12'h042);

        for (int v = 0; v < 256; v++) begin
            convert(W'(v), r, lat);
            ok = 1;
            val = 0;
            for (int i = D - 1; i >= 0; i--) begin
                if (r[4*i +: 4] > 4'd9) ok = 0;
                val = val * 10 + int'(r[4*i +: 4]);
            end
            chk("exh_digits", ok, 1);
            chk("exh_value", val, v);
            chk("exh_lat", lat, v == 0 ? ZLAT : W);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
